// File: rtl/load_store_pkg.sv
// Shared types and constants for the batch dispatcher and its request queue.
package load_store_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    XFER = 3'd2,
    DONE = 3'd3,
    COOL = 3'd4
  } state_t;

  localparam int N_DEFAULT     = 10000;
  localparam int CBITS_DEFAULT = 14;
  localparam int PEND_MAX      = 7;

endpackage

// File: rtl/req_queue.sv
// Turns rising edges of the upstream "tank full" level into queued batch
// requests: a saturating pending counter plus a sticky drop flag.
module req_queue
  import load_store_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       full_in,
  input  logic       deq,
  output logic [2:0] pending,
  output logic       drop
);

  localparam logic [2:0] PMAX = 3'(PEND_MAX);

  logic full_q;
  logic req;

  assign req = full_in && !full_q;

  // A request and a dequeue on the same edge cancel, so the counter holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      pending <= 3'd0;
      drop    <= 1'b0;
    end else begin
      full_q <= full_in;
      if (req && !deq) begin
        if (pending == PMAX) drop <= 1'b1;
        else                 pending <= pending + 3'd1;
      end else if (!req && deq && pending != 3'd0) begin
        pending <= pending - 3'd1;
      end
    end
  end

endmodule

// File: rtl/batch_dispatch.sv
// Batch dispatcher: for each queued request, streams word indices 0..N-1
// under valid/ready flow control, pulses done, then cools down.
module batch_dispatch
  import load_store_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int CBITS    = CBITS_DEFAULT,
  parameter int COOL_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             full_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CBITS-1:0] out_idx,
  output logic             busy,
  output logic             done,
  output logic [2:0]       pending,
  output logic             drop,
  output state_t           state_dbg
);

  // Handshake: a word transfers on a rising clk edge where out_valid && out_ready;
  // out_valid never drops and out_idx never changes until that transfer happens.

  localparam logic [CBITS-1:0] LAST  = CBITS'(N - 1);
  localparam logic [7:0]       COOL8 = 8'(COOL_CYC);

  state_t          state, state_nxt;
  logic [CBITS-1:0] idx;
  logic [7:0]       cool;
  logic             deq;
  logic             idx_inc;

  req_queue u_req_queue (
    .clk     (clk),
    .rst     (rst),
    .full_in (full_in),
    .deq     (deq),
    .pending (pending),
    .drop    (drop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    deq       = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    idx_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending != 3'd0) begin
          deq       = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: state_nxt = XFER;
      XFER: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx == LAST) state_nxt = DONE;
          else             idx_inc   = 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = COOL;
      end
      COOL: begin
        if (cool <= 8'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // idx_inc is only raised below LAST, so the index can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      cool <= 8'd0;
    end else begin
      if (state == ARM)  idx <= '0;
      else if (idx_inc)  idx <= idx + CBITS'(1);
      if (state == DONE)                    cool <= COOL8;
      else if (state == COOL && cool != 0)  cool <= cool - 8'd1;
    end
  end

  assign out_idx   = idx;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
